hwpe_ctrl_reqrsp2periph: RTL and testbench
==========================================

# hwpe_ctrl_reqrsp2periph

Bridge that terminates a `hwpe_ctrl_intf_reqrsp` target port and drives a `hwpe_ctrl_intf_periph` master port. It lets an HWPE controller or streamer that speaks req/rsp access peripheral-style slaves such as register files and TCDM ports. Every accepted request produces exactly one response. Because periph responses have no back-pressure (`r_valid` has no ready), the bridge issues a request only when the response it will produce has a reserved slot in an internal response FIFO.

## Interface
- `FIFO_DEPTH`, default 2: maximum in-flight transactions (outstanding plus buffered responses); must be ≥1.
- `ID_WIDTH`, default 1: periph `id`/`r_id` width; must be ≥1.
- `AW`/`DW` of the req/rsp side are fixed at 32.
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `clear_i`, input, 1: synchronous soft clear.
- `tgt`, `hwpe_ctrl_intf_reqrsp.target`, interface: upstream request/response port.
- `per`, `hwpe_ctrl_intf_periph.master`, interface: downstream periph port.
- `idle_o`, output, 1: high when no transaction is in flight.
- `err_o`, output, 1: sticky protocol-error flag.

## Operation
- Counter `cnt`, width $clog2(FIFO_DEPTH+1), range 0..FIFO_DEPTH, equals outstanding requests plus FIFO occupancy.
- `credit = (cnt < FIFO_DEPTH)`.
- Request path (combinational):
  - `per.req = tgt.q_valid & credit`
  - `per.add = q_addr`, `per.wen = ~q_write`, `per.be = q_strb`, `per.data = q_data`, `per.id = tag`
  - `tgt.q_ready = per.gnt & credit`
  - An accept is `per.req & per.gnt`.
- `tag` (ID_WIDTH bits) increments on every accept and wraps modulo 2^ID_WIDTH.
- Expected-tag register `etag` increments on every `r_valid`.
- On `per.r_valid`, push `r_data` into the FIFO. Reads and writes both push; the data of a write response is don't-care.
- `tgt.p_valid` is FIFO non-empty, and `tgt.p_data` is the FIFO head. A pop happens on `p_valid & p_ready`.
- Counter update: `cnt_next = cnt + accept - pop`. A push moves an entry from "outstanding" to "buffered" and leaves `cnt` unchanged.
- `err_o` sets on either of these and stays set until reset or `clear_i`:
  - `r_valid` while `r_id != etag`; the data is still pushed.
  - `r_valid` while no request is outstanding (`cnt` equals FIFO occupancy); the response is dropped and not pushed.
- `clear_i` resets `cnt`, `tag`, `etag`, FIFO pointers and `err_o` in the same cycle and has priority over every other update. Any data in flight is discarded. Software issues it only when `idle_o` is high.
- `idle_o = (cnt == 0)`.

## Timing
- Reset values:
  - `tgt.p_valid`=0, `tgt.p_data`=0, `err_o`=0, `idle_o`=1, `per.id`=0.
  - `per.req` follows `q_valid` (credit=1).
  - `tgt.q_ready` follows `per.gnt`.
- Request path is zero latency, combinational from `q_valid`/`gnt`. The bridge never drops `per.req` without a grant except when credit is exhausted.
- Response latency: `r_valid` in cycle N gives `p_valid` in cycle N+1. There is no combinational `r_valid`→`p_valid` path.
- The slave must assert `r_valid` no earlier than the cycle after the grant.
- FIFO full is impossible by construction. A push while full is a design error; flag it with an assertion.
- Simultaneous accept and pop: `cnt` is unchanged.
- Simultaneous push and pop on a 1-entry FIFO: head is replaced and `p_valid` stays high.
- With `cnt==FIFO_DEPTH`:
  - `per.req`=0 and `q_ready`=0.
  - A pop in cycle N restores credit in cycle N+1, not combinationally.
- Reset asserted mid-transaction: all state clears immediately. Late `r_valid` after reset sets `err_o`.

## Structure
- `hwpe_ctrl_package`:
  - Add `REQRSP2PERIPH_FIFO_DEPTH_DEFAULT = 2`.
  - Add a `reqrsp2periph_resp_t` struct holding `{data[31:0]}` so the entry can be widened later (e.g. error bit).
- Sub-module `hwpe_ctrl_resp_fifo`:
  - Register-based FIFO with parameterized depth.
  - Ports: `push_i`, `data_i`, `pop_i`, `data_o`, `empty_o`, `full_o`, `clear_i`.
  - Head register output, no fall-through.
- Top level holds the counter, tags, error flag and interface mapping.

## Test plan
- Single read: `q_addr=0x100`, `q_write=0`, `gnt=1`; slave returns `r_data=0xDEADBEEF` one cycle later → `per.wen=1`, `per.add=0x100`, `p_valid` in the cycle after `r_valid`, `p_data=0xDEADBEEF`, `idle_o` returns to 1 after the pop.
- Single write: `q_write=1`, `q_strb=4'b0011`, `q_data=0x1234` → `per.wen=0`, `be=0011`, `data=0x1234`; exactly one `p_valid` follows.
- Credit exhaustion: DEPTH=2, `p_ready=0`, three back-to-back reads with `gnt=1` → first two accepted (tags 0,1); third sees `q_ready=0` and `per.req=0` until one pop, then is accepted the following cycle.
- Back-pressure with stalls: random `gnt`/`p_ready` at 50%, 200 reads of address-as-data → responses in order, no loss, `err_o=0`, `cnt` never exceeds 2.
- Protocol error: inject `r_valid` with `r_id=1` when `etag=0` → `err_o=1` on the next cycle and stays 1; `clear_i` pulse → `err_o=0`, `idle_o=1`.
- Reset mid-flight: two reads outstanding, assert `rst_ni=0` asynchronously → `p_valid=0` and `idle_o=1` immediately; after release, a late `r_valid` → `err_o=1` and no push.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared constants and types for the HWPE control req/rsp-to-periph bridge.
package hwpe_ctrl_package;

    localparam int unsigned REQRSP2PERIPH_FIFO_DEPTH_DEFAULT = 2;

    // Kept as a struct so extra per-response fields (e.g. an error bit) can be added later.
    typedef struct packed {
        logic [31:0] data;
    } reqrsp2periph_resp_t;

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral-style request/grant interface with an unacknowledged response channel.
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = 1
);

    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );

endinterface

// File: rtl/hwpe_ctrl_intf_reqrsp.sv
// Request/response handshake interface with 32-bit address and data.
interface hwpe_ctrl_intf_reqrsp;

    logic        q_valid;
    logic        q_ready;
    logic [31:0] q_addr;
    logic        q_write;
    logic [3:0]  q_strb;
    logic [31:0] q_data;
    logic        p_valid;
    logic        p_ready;
    logic [31:0] p_data;

    modport initiator (
        output q_valid, q_addr, q_write, q_strb, q_data, p_ready,
        input  q_ready, p_valid, p_data
    );

    modport target (
        input  q_valid, q_addr, q_write, q_strb, q_data, p_ready,
        output q_ready, p_valid, p_data
    );

endinterface

// File: rtl/hwpe_ctrl_resp_fifo.sv
// Register-based response FIFO; the head is read straight from the storage registers,
// so there is no fall-through path from push to output.
module hwpe_ctrl_resp_fifo
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                push_i,
    input  reqrsp2periph_resp_t data_i,
    input  logic                pop_i,
    output reqrsp2periph_resp_t data_o,
    output logic                empty_o,
    output logic                full_o,
    output logic [CntW-1:0]     usage_o
);

    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    reqrsp2periph_resp_t mem_q [DEPTH];
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]     usage_q;
    logic                do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (usage_q == '0);
    assign full_o  = (usage_q == DepthC);
    assign usage_o = usage_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                usage_q <= usage_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                usage_q <= usage_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_reqrsp2periph.sv
// Bridges a req/rsp target port onto a periph master port, issuing a request only when
// its response already has a reserved slot in the response FIFO.
module hwpe_ctrl_reqrsp2periph
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned FIFO_DEPTH = REQRSP2PERIPH_FIFO_DEPTH_DEFAULT,
    parameter int unsigned ID_WIDTH   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    hwpe_ctrl_intf_reqrsp.target  tgt,
    hwpe_ctrl_intf_periph.master  per,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    // cnt_q counts outstanding requests plus buffered responses.
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     fifo_usage;
    logic [ID_WIDTH-1:0] tag_q, etag_q;
    logic                err_q;
    logic                credit, accept, pop, push, no_outstanding, id_err;
    logic                fifo_empty, fifo_full;
    reqrsp2periph_resp_t fifo_in, fifo_head;

    assign credit         = (cnt_q < DepthC);
    assign accept         = per.req & per.gnt;
    assign pop            = ~fifo_empty & tgt.p_ready;
    assign no_outstanding = (cnt_q == fifo_usage);
    assign push           = per.r_valid & ~no_outstanding;
    assign id_err         = per.r_valid & (per.r_id != etag_q);

    assign per.req     = tgt.q_valid & credit;
    assign per.add     = tgt.q_addr;
    assign per.wen     = ~tgt.q_write;
    assign per.be      = tgt.q_strb;
    assign per.data    = tgt.q_data;
    assign per.id      = tag_q;
    assign tgt.q_ready = per.gnt & credit;
    assign tgt.p_valid = ~fifo_empty;
    assign tgt.p_data  = fifo_head.data;

    assign fifo_in.data = per.r_data;
    assign idle_o       = (cnt_q == '0);
    assign err_o        = err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tag_q  <= '0;
            etag_q <= '0;
            err_q  <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            tag_q  <= '0;
            etag_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                tag_q <= tag_q + ID_WIDTH'(1);
            end
            if (per.r_valid) begin
                etag_q <= etag_q + ID_WIDTH'(1);
            end
            // Unexpected responses are dropped (not pushed) but still flagged.
            if (id_err || (per.r_valid && no_outstanding)) begin
                err_q <= 1'b1;
            end
        end
    end

    hwpe_ctrl_resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (fifo_in),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .usage_o (fifo_usage)
    );

    push_while_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !fifo_full);

endmodule

// File: tb/tb_hwpe_ctrl_reqrsp2periph.sv
// Scoreboard bench for hwpe_ctrl_reqrsp2periph with a simple in-order periph slave model.
module tb_hwpe_ctrl_reqrsp2periph;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic idle, err;

    hwpe_ctrl_intf_reqrsp tgt_if ();
    hwpe_ctrl_intf_periph #(.ID_WIDTH(1)) per_if ();

    hwpe_ctrl_reqrsp2periph #(
        .FIFO_DEPTH (DEPTH),
        .ID_WIDTH   (1)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .tgt     (tgt_if),
        .per     (per_if),
        .idle_o  (idle),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          care;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] d;
    } slv_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    slv_t slv_q[$];
    bit   auto_slave = 1'b1;
    int   n_pop = 0;
    int   m_infl = 0;
    logic m_tag = 1'b0;
    logic m_etag = 1'b0;
    logic last_acc = 1'b0;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : a;
    endfunction

    // One clock cycle: observe at the falling edge, then advance to just after the rising edge.
    task automatic tick();
        logic acc, pp;
        exp_t e;
        slv_t s;
        @(negedge clk);
        acc = per_if.req & per_if.gnt;
        pp  = tgt_if.p_valid & tgt_if.p_ready;
        checks++;
        if (idle !== (m_infl == 0)) begin
            errors++;
            $display("FAIL idle_track: idle_o=%b required %b (in flight %0d)", idle, m_infl == 0, m_infl);
        end
        if (m_infl >= int'(DEPTH)) begin
            checks++;
            if (per_if.req !== 1'b0 || tgt_if.q_ready !== 1'b0) begin
                errors++;
                $display("FAIL credit_block: req=%b q_ready=%b required 0/0", per_if.req, tgt_if.q_ready);
            end
        end
        if (pp) begin
            checks++;
            n_pop++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: p_data=%h with no response expected", tgt_if.p_data);
            end else begin
                e = sb.pop_front();
                if (e.care && tgt_if.p_data !== e.d) begin
                    errors++;
                    $display("FAIL resp_data: p_data=%h required %h", tgt_if.p_data, e.d);
                end
            end
        end
        if (acc) begin
            checks++;
            if (per_if.id !== m_tag) begin
                errors++;
                $display("FAIL req_tag: id=%b required %b", per_if.id, m_tag);
            end
            e.d    = slave_rd(per_if.add);
            e.care = per_if.wen;
            sb.push_back(e);
            s.id = m_tag;
            s.d  = per_if.wen ? slave_rd(per_if.add) : 32'h0BAD_0BAD;
            slv_q.push_back(s);
            m_tag = ~m_tag;
        end
        if (per_if.r_valid) m_etag = ~m_etag;
        m_infl = m_infl + int'(acc) - int'(pp);
        if (clear) begin
            m_tag  = 1'b0;
            m_etag = 1'b0;
            m_infl = 0;
            sb.delete();
            slv_q.delete();
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (auto_slave) begin
            if (slv_q.size() > 0) begin
                s = slv_q.pop_front();
                per_if.r_valid = 1'b1;
                per_if.r_id    = s.id;
                per_if.r_data  = s.d;
            end else begin
                per_if.r_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        tgt_if.q_valid = 1'b0;
        tgt_if.q_addr  = '0;
        tgt_if.q_write = 1'b0;
        tgt_if.q_strb  = 4'hF;
        tgt_if.q_data  = '0;
        tgt_if.p_ready = 1'b0;
        per_if.gnt     = 1'b0;
        per_if.r_valid = 1'b0;
        per_if.r_id    = 1'b0;
        per_if.r_data  = '0;
        rst_n = 1'b0;
        #3;
        checks++;
        if (tgt_if.p_valid !== 1'b0 || tgt_if.p_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: p_valid=%b p_data=%h required 0/0", tgt_if.p_valid, tgt_if.p_data);
        end
        checks++;
        if (err !== 1'b0 || idle !== 1'b1 || per_if.id !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: err=%b idle=%b id=%b required 0/1/0", err, idle, per_if.id);
        end
        tgt_if.q_valid = 1'b1;
        per_if.gnt     = 1'b1;
        #1;
        checks++;
        if (per_if.req !== 1'b1 || tgt_if.q_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_follow: req=%b q_ready=%b required 1/1", per_if.req, tgt_if.q_ready);
        end
        per_if.gnt = 1'b0;
        #1;
        checks++;
        if (per_if.req !== 1'b1 || tgt_if.q_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_nogrant: req=%b q_ready=%b required 1/0", per_if.req, tgt_if.q_ready);
        end
        tgt_if.q_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        tgt_if.q_valid = 1'b1;
        tgt_if.q_addr  = 32'h100;
        tgt_if.q_write = 1'b0;
        tgt_if.q_strb  = 4'hF;
        per_if.gnt     = 1'b1;
        tgt_if.p_ready = 1'b1;
        #1;
        checks++;
        if (per_if.wen !== 1'b1 || per_if.add !== 32'h100 || per_if.req !== 1'b1) begin
            errors++;
            $display("FAIL read_req: wen=%b add=%h req=%b required 1/100/1", per_if.wen, per_if.add, per_if.req);
        end
        tick();
        tgt_if.q_valid = 1'b0;
        checks++;
        if (tgt_if.p_valid !== 1'b0 || idle !== 1'b0) begin
            errors++;
            $display("FAIL read_latency: p_valid=%b idle=%b required 0/0", tgt_if.p_valid, idle);
        end
        tick();
        checks++;
        if (tgt_if.p_valid !== 1'b1 || tgt_if.p_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_resp: p_valid=%b p_data=%h required 1/deadbeef", tgt_if.p_valid, tgt_if.p_data);
        end
        tick();
        checks++;
        if (idle !== 1'b1 || tgt_if.p_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: idle=%b p_valid=%b required 1/0", idle, tgt_if.p_valid);
        end
    endtask

    task automatic test_single_write();
        int pops0;
        tgt_if.q_valid = 1'b1;
        tgt_if.q_addr  = 32'h200;
        tgt_if.q_write = 1'b1;
        tgt_if.q_strb  = 4'b0011;
        tgt_if.q_data  = 32'h1234;
        #1;
        checks++;
        if (per_if.wen !== 1'b0 || per_if.be !== 4'b0011 || per_if.data !== 32'h1234) begin
            errors++;
            $display("FAIL write_req: wen=%b be=%b data=%h required 0/0011/1234", per_if.wen, per_if.be, per_if.data);
        end
        pops0 = n_pop;
        tick();
        tgt_if.q_valid = 1'b0;
        tgt_if.q_write = 1'b0;
        tgt_if.q_strb  = 4'hF;
        repeat (6) tick();
        checks++;
        if (n_pop - pops0 != 1) begin
            errors++;
            $display("FAIL write_resp_count: %0d responses required 1", n_pop - pops0);
        end
    endtask

    task automatic test_credit();
        int k;
        tgt_if.p_ready = 1'b0;
        per_if.gnt     = 1'b1;
        tgt_if.q_valid = 1'b1;
        tgt_if.q_addr  = 32'h10;
        tick();
        tgt_if.q_addr = 32'h14;
        tick();
        tgt_if.q_addr = 32'h18;
        #1;
        checks++;
        if (per_if.req !== 1'b0 || tgt_if.q_ready !== 1'b0) begin
            errors++;
            $display("FAIL credit_full: req=%b q_ready=%b required 0/0", per_if.req, tgt_if.q_ready);
        end
        repeat (3) tick();
        tgt_if.p_ready = 1'b1;
        #1;
        checks++;
        if (per_if.req !== 1'b0) begin
            errors++;
            $display("FAIL credit_comb: req=%b during pop required 0", per_if.req);
        end
        tick();
        tgt_if.p_ready = 1'b0;
        #1;
        checks++;
        if (per_if.req !== 1'b1 || tgt_if.q_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_restore: req=%b q_ready=%b required 1/1", per_if.req, tgt_if.q_ready);
        end
        tick();
        tgt_if.q_valid = 1'b0;
        checks++;
        if (last_acc !== 1'b1) begin
            errors++;
            $display("FAIL credit_accept: accepted=%b required 1", last_acc);
        end
        tgt_if.p_ready = 1'b1;
        k = 0;
        while ((sb.size() != 0 || m_infl != 0) && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL credit_drain: %0d responses outstanding required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int n, k;
        n = 0;
        k = 0;
        tgt_if.q_valid = 1'b1;
        tgt_if.q_write = 1'b0;
        tgt_if.q_addr  = 32'h1000;
        while (n < 200 && k < 5000) begin
            per_if.gnt     = 1'($urandom_range(0, 1));
            tgt_if.p_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
            if (last_acc) begin
                n++;
                tgt_if.q_addr = 32'h1000 + 32'(n * 4);
            end
            if (n == 200) tgt_if.q_valid = 1'b0;
        end
        tgt_if.q_valid = 1'b0;
        k = 0;
        while ((sb.size() != 0 || m_infl != 0) && k < 500) begin
            tgt_if.p_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        checks++;
        if (n != 200 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_complete: accepted %0d pending %0d required 200/0", n, sb.size());
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err: err=%b required 0", err);
        end
    endtask

    task automatic test_protocol_error();
        slv_t s;
        auto_slave     = 1'b0;
        per_if.r_valid = 1'b0;
        tgt_if.p_ready = 1'b0;
        per_if.gnt     = 1'b1;
        tgt_if.q_valid = 1'b1;
        tgt_if.q_addr  = 32'h300;
        tick();
        tgt_if.q_valid = 1'b0;
        s = slv_q.pop_front();
        per_if.r_valid = 1'b1;
        per_if.r_id    = ~m_etag;
        per_if.r_data  = s.d;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL perr_before: err=%b required 0", err);
        end
        tick();
        per_if.r_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL perr_set: err=%b required 1", err);
        end
        tgt_if.p_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: err=%b required 1", err);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (err !== 1'b0 || idle !== 1'b1 || per_if.id !== 1'b0) begin
            errors++;
            $display("FAIL perr_clear: err=%b idle=%b id=%b required 0/1/0", err, idle, per_if.id);
        end
    endtask

    task automatic test_reset_midflight();
        slv_t s;
        tgt_if.p_ready = 1'b0;
        per_if.gnt     = 1'b1;
        tgt_if.q_valid = 1'b1;
        tgt_if.q_addr  = 32'h400;
        tick();
        tgt_if.q_addr = 32'h404;
        tick();
        tgt_if.q_valid = 1'b0;
        s = slv_q.pop_front();
        per_if.r_valid = 1'b1;
        per_if.r_id    = s.id;
        per_if.r_data  = s.d;
        tick();
        per_if.r_valid = 1'b0;
        checks++;
        if (tgt_if.p_valid !== 1'b1 || idle !== 1'b0) begin
            errors++;
            $display("FAIL mid_inflight: p_valid=%b idle=%b required 1/0", tgt_if.p_valid, idle);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tgt_if.p_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_rst: p_valid=%b idle=%b required 0/1", tgt_if.p_valid, idle);
        end
        m_tag  = 1'b0;
        m_etag = 1'b0;
        m_infl = 0;
        sb.delete();
        slv_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        per_if.r_valid = 1'b1;
        per_if.r_id    = 1'b0;
        per_if.r_data  = 32'hBAD0_0001;
        tick();
        per_if.r_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || tgt_if.p_valid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL late_resp: err=%b p_valid=%b idle=%b required 1/0/1", err, tgt_if.p_valid, idle);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_credit();
        test_back_to_back();
        test_protocol_error();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
